// File: rtl/multi_channel_producer_pkg.sv
// Shared encodings and defaults for the multi-channel request producer.
// FSM states, address-mode encodings and default widths live here.
package multi_channel_producer_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int ID_WIDTH      = 8;

   localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

   localparam logic MODE_SEQ  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/multi_channel_producer_channel.sv
// One request stream: address generator (stride or Galois LFSR), issue ID,
// request counter and valid/stall handling for a single channel.
module producer_channel
   import multi_channel_producer_pkg::*;
#(
   parameter int          CH        = 0,
   parameter int          ADDR_W    = ADDRESS_WIDTH,
   parameter int          ID_W      = ID_WIDTH,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              load_mode,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-1:0] load_stride,
   input  logic [CNT_W-1:0]  load_count,
   input  logic              mode,
   input  logic [ADDR_W-1:0] step,
   input  logic [CNT_W-1:0]  count,
   input  logic              stall,
   output logic [ADDR_W-1:0] address,
   output logic [ID_W-1:0]   id,
   output logic              valid,
   output logic              channel_done
);

   localparam logic [ADDR_W-1:0] TAPS = ADDR_W'(LFSR_TAPS);

   logic [CNT_W-1:0]  issued;
   logic              done_r;
   logic              xfer;
   logic              last;
   logic [ADDR_W-1:0] seq_first;
   logic [ADDR_W-1:0] seed_raw;
   logic [ADDR_W-1:0] seed;
   logic [ADDR_W-1:0] lfsr_next;

   // Handshake: a transfer happens on a rising edge where valid=1 and stall=0;
   // while stalled, address/id/valid hold, and stall is ignored when valid=0.
   assign xfer = valid & ~stall;
   assign last = (issued == count - CNT_W'(1));

   assign seq_first = load_base + ADDR_W'(CH) * load_stride;
   assign seed_raw  = load_base ^ ADDR_W'(CH + 1);
   assign seed      = (seed_raw == '0) ? ADDR_W'(1) : seed_raw;
   assign lfsr_next = {1'b0, address[ADDR_W-1:1]} ^ (address[0] ? TAPS : '0);

   // Done also covers the edge of the final transfer so the FSM can leave RUN on it.
   assign channel_done = done_r | (xfer & last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address <= '0;
         id      <= '0;
         issued  <= '0;
         valid   <= 1'b0;
         done_r  <= 1'b0;
      end else if (load) begin
         address <= load_mode ? seed : seq_first;
         id      <= '0;
         issued  <= '0;
         valid   <= (load_count != '0);
         done_r  <= (load_count == '0);
      end else if (xfer) begin
         address <= mode ? lfsr_next : address + step;
         id      <= id + ID_W'(1);
         issued  <= issued + CNT_W'(1);
         if (last) begin
            valid  <= 1'b0;
            done_r <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_channel_producer.sv
// Job-level control for NUM_CH independent request streams: start/done FSM,
// latched job configuration and packing of the per-channel outputs.
module multi_channel_producer
   import multi_channel_producer_pkg::*;
#(
   parameter int          NUM_CH    = 2,
   parameter int          ADDR_W    = ADDRESS_WIDTH,
   parameter int          ID_W      = ID_WIDTH,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] LFSR_TAPS = DEFAULT_LFSR_TAPS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_start,
   input  logic                     in_mode,
   input  logic [ADDR_W-1:0]        in_base_addr,
   input  logic [ADDR_W-1:0]        in_stride,
   input  logic [CNT_W-1:0]         in_count,
   input  logic [NUM_CH-1:0]        in_stall,
   output logic [NUM_CH*ADDR_W-1:0] out_address,
   output logic [NUM_CH*ID_W-1:0]   out_id,
   output logic [NUM_CH-1:0]        out_valid,
   output logic                     out_busy,
   output logic                     out_done
);

   state_t              state;
   state_t              state_next;
   logic                cfg_mode;
   logic [ADDR_W-1:0]   cfg_step;
   logic [CNT_W-1:0]    cfg_count;
   logic                load;
   logic [NUM_CH-1:0]   ch_done;

   assign load = (state == ST_IDLE) && in_start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cfg_mode  <= MODE_SEQ;
         cfg_step  <= '0;
         cfg_count <= '0;
         out_busy  <= 1'b0;
         out_done  <= 1'b0;
      end else begin
         state    <= state_next;
         out_busy <= (state_next == ST_RUN);
         // Completion is reported one cycle after DONE is entered.
         out_done <= (state == ST_DONE);
         if (load) begin
            cfg_mode  <= in_mode;
            cfg_step  <= in_stride * ADDR_W'(NUM_CH);
            cfg_count <= in_count;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (in_start) state_next = (in_count == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (&ch_done) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      producer_channel #(
         .CH        (c),
         .ADDR_W    (ADDR_W),
         .ID_W      (ID_W),
         .CNT_W     (CNT_W),
         .LFSR_TAPS (LFSR_TAPS)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .load         (load),
         .load_mode    (in_mode == MODE_LFSR),
         .load_base    (in_base_addr),
         .load_stride  (in_stride),
         .load_count   (in_count),
         .mode         (cfg_mode == MODE_LFSR),
         .step         (cfg_step),
         .count        (cfg_count),
         .stall        (in_stall[c]),
         .address      (out_address[c*ADDR_W +: ADDR_W]),
         .id           (out_id[c*ID_W +: ID_W]),
         .valid        (out_valid[c]),
         .channel_done (ch_done[c])
      );
   end

endmodule

// File: tb/tb_multi_channel_producer.sv
// Directed and randomized jobs checked against a per-channel expected-request
// model built from the address/ID rules, plus completion and busy timing.
module tb_multi_channel_producer;
   import multi_channel_producer_pkg::*;

   localparam int NC = 2;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int CW = 16;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic           clk;
   logic           reset;
   logic           in_start;
   logic           in_mode;
   logic [AW-1:0]  in_base_addr;
   logic [AW-1:0]  in_stride;
   logic [CW-1:0]  in_count;
   logic [NC-1:0]  in_stall;
   logic [NC*AW-1:0] out_address;
   logic [NC*IW-1:0] out_id;
   logic [NC-1:0]  out_valid;
   logic           out_busy;
   logic           out_done;

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] exp_addr_q [NC][$];
   logic [IW-1:0] exp_id_q   [NC][$];

   multi_channel_producer #(
      .NUM_CH (NC), .ADDR_W (AW), .ID_W (IW), .CNT_W (CW), .LFSR_TAPS (TAPS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_start     (in_start),
      .in_mode      (in_mode),
      .in_base_addr (in_base_addr),
      .in_stride    (in_stride),
      .in_count     (in_count),
      .in_stall     (in_stall),
      .out_address  (out_address),
      .out_id       (out_id),
      .out_valid    (out_valid),
      .out_busy     (out_busy),
      .out_done     (out_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] lfsr_step(input logic [AW-1:0] v);
      logic [AW-1:0] n;
      n = v / 2;
      if (v % 2 == 1) n = n ^ TAPS;
      return n;
   endfunction

   // stall_mode: 0 none, 1 random, 2 ch1 stalled in cycles 2 and 3
   task automatic run_job(input logic mode, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                          input logic [CW-1:0] count, input int stall_mode, input bit poke_start);
      int rem [NC];
      int cyc, last_cyc, done_cyc, limit;
      logic [NC-1:0] stl;
      logic [AW-1:0] v;
      bit all_zero;
      for (int c = 0; c < NC; c++) begin
         exp_addr_q[c].delete();
         exp_id_q[c].delete();
         v = base ^ AW'(c + 1);
         if (v == 0) v = 1;
         for (int k = 0; k < int'(count); k++) begin
            if (mode) begin
               exp_addr_q[c].push_back(v);
               v = lfsr_step(v);
            end else begin
               exp_addr_q[c].push_back(base + AW'(c + k * NC) * stride);
            end
            exp_id_q[c].push_back(IW'(k % 256));
         end
         rem[c] = int'(count);
      end
      in_mode = mode; in_base_addr = base; in_stride = stride; in_count = count;
      in_stall = '0;
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
      last_cyc = (count == 0) ? 0 : -1;
      done_cyc = (count == 0) ? 2 : -1;
      limit = int'(count) * 8 + 64;
      cyc = 1;
      while (1) begin
         for (int c = 0; c < NC; c++) begin
            check($sformatf("valid%0d_c%0d", c, cyc), 64'(out_valid[c]), 64'(rem[c] > 0));
            if (rem[c] > 0) begin
               check($sformatf("addr%0d_c%0d", c, cyc), 64'(out_address[c*AW +: AW]), 64'(exp_addr_q[c][0]));
               check($sformatf("id%0d_c%0d", c, cyc), 64'(out_id[c*IW +: IW]), 64'(exp_id_q[c][0]));
            end
         end
         check($sformatf("done_c%0d", cyc), 64'(out_done), 64'(cyc == done_cyc));
         check($sformatf("busy_c%0d", cyc), 64'(out_busy), 64'(count != 0 && last_cyc < 0));
         if (done_cyc > 0 && cyc > done_cyc) break;
         if (cyc > limit) begin
            check("job_timeout", 64'(cyc), 64'(limit));
            break;
         end
         case (stall_mode)
            1: stl = NC'($urandom_range(0, 3));
            2: stl = (cyc == 2 || cyc == 3) ? 2'b10 : 2'b00;
            default: stl = '0;
         endcase
         in_stall = stl;
         in_start = poke_start && (cyc == 2);
         for (int c = 0; c < NC; c++) begin
            if (rem[c] > 0 && !stl[c]) begin
               void'(exp_addr_q[c].pop_front());
               void'(exp_id_q[c].pop_front());
               rem[c]--;
            end
         end
         all_zero = 1'b1;
         for (int c = 0; c < NC; c++) if (rem[c] != 0) all_zero = 1'b0;
         if (last_cyc < 0 && all_zero) begin
            last_cyc = cyc;
            done_cyc = cyc + 2;
         end
         @(negedge clk);
         cyc++;
      end
      in_stall = '0;
      in_start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_start = 1'b0; in_mode = 1'b0;
      in_base_addr = '0; in_stride = '0; in_count = '0; in_stall = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(out_busy), 64'(0));
      check("rst_done", 64'(out_done), 64'(0));
      reset = 1'b1;
      @(negedge clk);

      // Basic sequential job, then the same job with ch1 stalled on 0x100C
      run_job(1'b0, 32'h1000, 32'd4, 16'd3, 0, 1'b0);
      run_job(1'b0, 32'h1000, 32'd4, 16'd3, 2, 1'b0);
      // Address wrap, zero count, ID wrap across 300 requests
      run_job(1'b0, 32'hFFFF_FFF8, 32'd4, 16'd2, 0, 1'b0);
      run_job(1'b0, 32'h1234, 32'd8, 16'd0, 0, 1'b0);
      run_job(1'b0, 32'h0, 32'd1, 16'd300, 1, 1'b0);
      // LFSR from base 0 with a start pulse during RUN
      run_job(1'b1, 32'h0, 32'd0, 16'd2, 0, 1'b1);
      run_job(1'b1, 32'h0, 32'd0, 16'd12, 1, 1'b0);

      for (int i = 0; i < 6; i++)
         run_job(1'(i % 2), $urandom, $urandom, CW'($urandom_range(1, 20)), 1, 1'b0);

      // Asynchronous reset mid-job
      in_mode = 1'b0; in_base_addr = 32'h2000; in_stride = 32'd16; in_count = 16'd10;
      in_stall = '0;
      in_start = 1'b1;
      @(negedge clk);
      in_start = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'(2'b11));
      reset = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'(0));
      check("arst_addr", 64'(out_address), 64'(0));
      check("arst_id", 64'(out_id), 64'(0));
      check("arst_busy", 64'(out_busy), 64'(0));
      check("arst_done", 64'(out_done), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_state", 64'(dut.state), 64'(ST_IDLE));
      check("post_rst_busy", 64'(out_busy), 64'(0));
      check("post_rst_valid", 64'(out_valid), 64'(0));
      check("post_rst_done", 64'(out_done), 64'(0));

      // A fresh job after reset runs normally
      run_job(1'b0, 32'h40, 32'd2, 16'd5, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multi_channel_producer.md
Name: multi_channel_producer

Overview:
- Parametrised successor to the two-channel request producer.
- Generates NUM_CH independent address/ID request streams from one programmed job (base, stride, count, mode), with per-channel valid/stall flow control.
- Sits upstream of the consumer/arbiter fabric and drives its request channels.
- Adds job start/done control, sequential-stride and LFSR address modes, and address/ID wrap handling.

Parameters:
- NUM_CH, 2, number of request channels (1..8).
- ADDR_W, `ADDRESS_WIDTH, address width per channel.
- ID_W, `ID_WIDTH, ID width per channel.
- CNT_W, 16, width of the per-channel request count.
- LFSR_TAPS, 32'h8020_0003, Galois tap mask (low ADDR_W bits used), used in LFSR mode.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- in_start  in  1  start pulse; sampled only in IDLE.
- in_mode  in  1  0 = sequential stride, 1 = LFSR; latched at start.
- in_base_addr  in  ADDR_W  job base address; latched at start.
- in_stride  in  ADDR_W  address stride; latched at start.
- in_count  in  CNT_W  requests per channel; latched at start.
- in_stall  in  NUM_CH  per-channel stall from consumer.
- out_address  out  NUM_CH*ADDR_W  packed addresses; channel c occupies [c*ADDR_W +: ADDR_W].
- out_id  out  NUM_CH*ID_W  packed IDs, same packing.
- out_valid  out  NUM_CH  per-channel request valid.
- out_busy  out  1  job in progress.
- out_done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (reset==0, async): FSM to IDLE; all outputs 0; all counters and LFSRs cleared. This applies mid-job; in-flight requests are dropped with no completion.
- FSM states:
  - IDLE: in_start=1 at edge T latches config. If in_count!=0, go to RUN; out_busy=1 and out_valid=all-ones from T+1. If in_count==0, go to DONE.
  - RUN: remain until every channel has issued in_count transfers.
  - DONE: out_done=1 and out_busy=0 for exactly one cycle, then return to IDLE.
- in_start is ignored outside IDLE.
- Transfer: occurs on channel c when out_valid[c]=1 and in_stall[c]=0 at a rising edge.
- Stall: while stalled, address, ID and valid are held stable. in_stall[c] has no effect when out_valid[c]=0.
- Back-to-back issue, no bubbles: the next request is presented in the cycle after each transfer.
- After its last transfer, a channel drops valid and stays idle until the job ends. Channels are fully independent; stalling one never affects another.
- Completion: DONE is entered the cycle after the final transfer of the last channel. out_done is high the following cycle, with simultaneous last transfers on several channels handled identically.
- Sequential mode:
  - Request k of channel c has address base + (c + k*NUM_CH)*stride, truncated to ADDR_W (modulo wrap, no error).
  - Computed incrementally: a per-channel address register starts at base + c*stride and adds NUM_CH*stride per transfer.
- LFSR mode:
  - Per-channel Galois LFSR seeded with base XOR (c+1); a zero seed is forced to 1.
  - The first request uses the seed; each transfer advances one step: shift right, XOR LFSR_TAPS if the shifted-out bit was 1.
  - The state never reaches 0.
- ID: per-channel issue index k, truncated to ID_W; wraps from 2^ID_W-1 to 0.
- Request counter: CNT_W bits, compared against the latched count. The maximum count of 2^CNT_W-1 is supported.

Decomposition:
- defines.vh gains: FSM state encodings (IDLE/RUN/DONE), mode encodings (MODE_SEQ=0, MODE_LFSR=1), default LFSR tap constant.
- Sub-module producer_channel, instantiated NUM_CH times via generate. It holds the address register/LFSR, ID counter, request counter and valid/stall logic, and outputs a channel_done flag.
- The top level holds the FSM, config latches and packing.

Test Plan:
- Reset: drive reset=0 mid-RUN with valids high -> all outputs 0 immediately; after release, FSM is IDLE and out_busy=0.
- Sequential, NUM_CH=2, base=0x1000, stride=4, count=3, no stall:
  - ch0 issues 0x1000, 0x1008, 0x1010 with IDs 0, 1, 2; ch1 issues 0x1004, 0x100C, 0x1014.
  - valid spans T+1..T+3; out_done pulses at T+5.
- Same job with in_stall[1]=1 for 2 cycles while ch1 presents 0x100C:
  - 0x100C and ID 1 are held stable; ch0 finishes unaffected.
  - out_done is delayed by 2 cycles.
- Wrap: base=0xFFFF_FFF8, stride=4, count=2 -> ch0 issues 0xFFFF_FFF8, 0x0000_0000; ch1 issues 0xFFFF_FFFC, 0x0000_0004.
- Edge counts:
  - count=0 -> out_valid never rises; out_done pulses at T+2.
  - count=300 with ID_W=8 -> ID 255 is followed by 0; 300 transfers per channel.
- LFSR mode, ADDR_W=32, base=0:
  - ch0 seed is 1, next value is 0x8020_0003; ch1 seed is 2, next value is 1.
  - in_start pulsed during RUN is ignored.
